spi_mem_arbiter: RTL and testbench

//  Shares the single SPI memory engine (mem_external) between N_REQ requesters:
//  0 = CPU instruction fetch, 1 = CPU load/store, 2 = debug/program loader.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/spi_mem_arbiter_if.sv | 36 +++
 rtl/rr_picker.sv | 27 ++
 rtl/spi_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_spi_mem_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the SPI memory arbiter slice.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LSU   = 1;
  localparam int REQ_DBG   = 2;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 32;
  localparam int NBYTES_W = 3;

  localparam logic [NBYTES_W-1:0] NBYTES_1 = 3'd1;
  localparam logic [NBYTES_W-1:0] NBYTES_2 = 3'd2;
  localparam logic [NBYTES_W-1:0] NBYTES_4 = 3'd4;

  // Index of the set bit in a one-hot vector of up to four requesters.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Requester-side and engine-side signals of the arbiter; master = arbiter, slave = its environment.
interface spi_mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int N_REQ = 3
) ();

  logic [N_REQ-1:0]               req;
  logic [N_REQ-1:0]               req_we;
  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr;
  logic [N_REQ-1:0][NBYTES_W-1:0] req_nbytes;
  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata;
  logic [N_REQ-1:0]               gnt;
  logic [N_REQ-1:0]               done;
  logic [N_REQ-1:0]               err;
  logic [DATA_W-1:0]              rdata;

  logic                           mem_start;
  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_addr;
  logic [NBYTES_W-1:0]            mem_nbytes;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           mem_done;
  logic [DATA_W-1:0]              mem_rdata;

  modport master (
    input  req, req_we, req_addr, req_nbytes, req_wdata, mem_done, mem_rdata,
    output gnt, done, err, rdata, mem_start, mem_we, mem_addr, mem_nbytes, mem_wdata
  );

  modport slave (
    output req, req_we, req_addr, req_nbytes, req_wdata, mem_done, mem_rdata,
    input  gnt, done, err, rdata, mem_start, mem_we, mem_addr, mem_nbytes, mem_wdata
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin from ptr_i, or fixed lowest-index priority.
module rr_picker #(
  parameter int N       = 3,
  parameter bit RR_MODE = 1'b1,
  localparam int PTR_W  = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     win_o,
  output logic             any_o
);

  logic [PTR_W-1:0] base;
  logic [N-1:0]     rot;
  logic [N-1:0]     pick;
  logic [2*N-1:0]   win_dbl;

  assign base = RR_MODE ? ptr_i : '0;

  // Rotate so the search start sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot     = N'({req_i, req_i} >> base);
  assign pick    = rot & (~rot + N'(1));
  assign win_dbl = {{N{1'b0}}, pick} << base;
  assign win_o   = win_dbl[N-1:0] | win_dbl[2*N-1:N];
  assign any_o   = |req_i;

endmodule

// File: rtl/spi_mem_arbiter.sv
// Shares one SPI memory engine between N_REQ requesters through a start/done handshake.
module spi_mem_arbiter
  import mem_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT_CYC = 4095
) (
  input logic               clk,
  input logic               rst_n,
  spi_mem_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  arb_state_t          state_q;
  logic [N_REQ-1:0]    req_q;
  logic [N_REQ-1:0]    req_live;
  logic [N_REQ-1:0]    win;
  logic                any_req;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_d;
  logic [N_REQ-1:0]    gnt_q;
  logic [N_REQ-1:0]    done_q;
  logic [N_REQ-1:0]    err_q;
  logic                start_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NBYTES_W-1:0] nbytes_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                timeout_hit;

  // A request must be seen on two consecutive edges; one that drops in between is forgotten.
  assign req_live = req_q & bus.req;

  rr_picker #(
    .N       (N_REQ),
    .RR_MODE (RR_MODE != 0)
  ) u_picker (
    .req_i (req_live),
    .ptr_i (ptr_q),
    .win_o (win),
    .any_o (any_req)
  );

  assign win_idx     = PTR_W'(onehot_to_idx(4'(win)));
  assign ptr_d       = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // NOTE: every register here is state, so only non-blocking assignments are used; a blocking
  // write would make later reads in the same block see the new value and break the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      nbytes_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      req_q  <= bus.req;
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (any_req && !bus.mem_done) begin
            state_q  <= BUSY;
            gnt_q    <= win;
            start_q  <= 1'b1;
            we_q     <= bus.req_we[win_idx];
            addr_q   <= bus.req_addr[win_idx];
            nbytes_q <= bus.req_nbytes[win_idx];
            wdata_q  <= bus.req_wdata[win_idx];
            ptr_q    <= ptr_d;
            cnt_q    <= '0;
          end
        end
        BUSY: begin
          // Completion is checked before the timeout so a coincident done is never reported as err.
          if (bus.mem_done) begin
            if (!we_q) rdata_q <= bus.mem_rdata;
            done_q  <= gnt_q;
            gnt_q   <= '0;
            start_q <= 1'b0;
            state_q <= RELEASE;
          end else if (timeout_hit) begin
            err_q   <= gnt_q;
            gnt_q   <= '0;
            start_q <= 1'b0;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!bus.mem_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_start  = start_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_nbytes = nbytes_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Scoreboard bench: a round-robin arbiter (long timeout) and a fixed-priority one (TIMEOUT_CYC=16).
module tb_spi_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_arbiter_if #(.N_REQ(3)) ia ();
  spi_mem_arbiter_if #(.N_REQ(3)) ib ();

  spi_mem_arbiter #(.N_REQ(3), .RR_MODE(1), .TIMEOUT_CYC(4095)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.master));
  spi_mem_arbiter #(.N_REQ(3), .RR_MODE(0), .TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.master));

  typedef struct {
    int          idx;
    bit          is_err;
    bit          we;
    logic [31:0] rd;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rd_a = '0;
  logic [31:0] last_rd_b = '0;
  int          lat_a = 3;
  int          lat_b = 3;
  bit          never_a = 1'b0;
  bit          never_b = 1'b0;

  function automatic logic [31:0] mem_word(input logic [24:0] a);
    return (a == 25'h100) ? 32'h1300_0000 : ({7'd0, a} ^ 32'hC0DE_0000);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Engine models: raise mem_done lat cycles after mem_start, hold it until mem_start falls.
  initial begin : model_a
    int c;
    c = 0;
    ia.mem_done = 1'b0;
    ia.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!ia.mem_start) begin
        ia.mem_done = 1'b0;
        c = 0;
      end else if (!ia.mem_done && !never_a) begin
        if (c == lat_a) begin
          ia.mem_done = 1'b1;
          ia.mem_rdata = mem_word(ia.mem_addr);
        end else c++;
      end
    end
  end

  initial begin : model_b
    int c;
    c = 0;
    ib.mem_done = 1'b0;
    ib.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!ib.mem_start) begin
        ib.mem_done = 1'b0;
        c = 0;
      end else if (!ib.mem_done && !never_b) begin
        if (c == lat_b) begin
          ib.mem_done = 1'b1;
          ib.mem_rdata = mem_word(ib.mem_addr);
        end else c++;
      end
    end
  end

  initial begin : monitor
    exp_t       it;
    logic [2:0] ed, ee;
    forever begin
      @(negedge clk);
      n_checks++;
      if (!$onehot0(ia.gnt) || !$onehot0(ib.gnt)) begin
        n_fail++;
        $display("FAIL gnt_onehot: a=%b b=%b, required at most one bit set", ia.gnt, ib.gnt);
      end
      if ((ia.done | ia.err) != '0) begin
        n_checks++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected_pulse: done=%b err=%b, required none", ia.done, ia.err);
        end else begin
          it = q_a.pop_front();
          ed = it.is_err ? 3'b000 : 3'(1 << it.idx);
          ee = it.is_err ? 3'(1 << it.idx) : 3'b000;
          if (ia.done !== ed || ia.err !== ee) begin
            n_fail++;
            $display("FAIL a_pulse: done=%b err=%b, required done=%b err=%b", ia.done, ia.err, ed, ee);
          end
          if (!it.is_err && !it.we) last_rd_a = it.rd;
          n_checks++;
          if (ia.rdata !== last_rd_a) begin
            n_fail++;
            $display("FAIL a_rdata: got %h, required %h", ia.rdata, last_rd_a);
          end
        end
      end
      if ((ib.done | ib.err) != '0) begin
        n_checks++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected_pulse: done=%b err=%b, required none", ib.done, ib.err);
        end else begin
          it = q_b.pop_front();
          ed = it.is_err ? 3'b000 : 3'(1 << it.idx);
          ee = it.is_err ? 3'(1 << it.idx) : 3'b000;
          if (ib.done !== ed || ib.err !== ee) begin
            n_fail++;
            $display("FAIL b_pulse: done=%b err=%b, required done=%b err=%b", ib.done, ib.err, ed, ee);
          end
          if (!it.is_err && !it.we) last_rd_b = it.rd;
          n_checks++;
          if (ib.rdata !== last_rd_b) begin
            n_fail++;
            $display("FAIL b_rdata: got %h, required %h", ib.rdata, last_rd_b);
          end
        end
      end
    end
  end

  task automatic wait_idle(input bit use_b, input string name);
    int cyc;
    cyc = 0;
    while ((use_b ? q_b.size() : q_a.size()) != 0 && cyc < 400) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc >= 400) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name,
               use_b ? q_b.size() : q_a.size());
    end
    step();
  endtask

  task automatic wait_grant(input bit use_b, input string name, output int cyc);
    cyc = 0;
    while ((use_b ? ib.gnt : ia.gnt) == '0 && cyc < 20) begin
      step();
      cyc++;
    end
    n_checks++;
    if (cyc >= 20) begin
      n_fail++;
      $display("FAIL %s_grant_timeout: no gnt after %0d cycles, required a grant", name, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_checks++;
    if ({ia.gnt, ia.done, ia.err, ia.mem_start, ia.mem_we} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl_a: gnt=%b done=%b err=%b start=%b we=%b, required all 0",
               ia.gnt, ia.done, ia.err, ia.mem_start, ia.mem_we);
    end
    n_checks++;
    if (ia.mem_addr !== '0 || ia.mem_nbytes !== '0 || ia.mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_payload_a: addr=%h nbytes=%h wdata=%h, required 0",
               ia.mem_addr, ia.mem_nbytes, ia.mem_wdata);
    end
    n_checks++;
    if (ia.rdata !== '0 || ib.rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: a=%h b=%h, required 0", ia.rdata, ib.rdata);
    end
    n_checks++;
    if ({ib.gnt, ib.done, ib.err, ib.mem_start, ib.mem_we, ib.mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: gnt=%b start=%b addr=%h, required 0", ib.gnt, ib.mem_start, ib.mem_addr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_contention_rr();
    logic [24:0] addrs[3];
    bit          prev;
    int          rises, cyc;
    addrs = '{25'h200, 25'h1000300, 25'h400};
    lat_a = 2;
    for (int i = 0; i < 3; i++) begin
      ia.req_we[i] = 1'b0;
      ia.req_addr[i] = addrs[i];
      ia.req_nbytes[i] = NBYTES_4;
    end
    for (int k = 0; k < 6; k++)
      q_a.push_back('{idx: k % 3, is_err: 1'b0, we: 1'b0, rd: mem_word(addrs[k % 3])});
    ia.req = 3'b111;
    prev = 1'b0;
    rises = 0;
    cyc = 0;
    while (q_a.size() != 0 && cyc < 300) begin
      step();
      cyc++;
      if (ia.mem_start && !prev) begin
        n_checks++;
        if (ia.gnt !== 3'(1 << (rises % 3))) begin
          n_fail++;
          $display("FAIL rr_order: grant %0d gnt=%b, required %b", rises, ia.gnt, 3'(1 << (rises % 3)));
        end
        rises++;
      end
      prev = ia.mem_start;
    end
    ia.req = 3'b000;
    n_checks++;
    if (rises != 6) begin
      n_fail++;
      $display("FAIL rr_start_pulses: %0d separate mem_start pulses, required 6", rises);
    end
    wait_idle(1'b0, "rr");
  endtask

  task automatic test_single_fetch();
    int cyc, hi;
    lat_a = 39;
    ia.req_we[REQ_FETCH] = 1'b0;
    ia.req_addr[REQ_FETCH] = 25'h000100;
    ia.req_nbytes[REQ_FETCH] = NBYTES_4;
    q_a.push_back('{idx: REQ_FETCH, is_err: 1'b0, we: 1'b0, rd: 32'h1300_0000});
    ia.req = 3'b001;
    wait_grant(1'b0, "fetch", cyc);
    n_checks++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL fetch_latency: gnt after %0d cycles, required 2", cyc);
    end
    n_checks++;
    if (ia.gnt !== 3'b001 || !ia.mem_start || ia.mem_addr !== 25'h100 ||
        ia.mem_nbytes !== NBYTES_4 || ia.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_issue: gnt=%b start=%b addr=%h nbytes=%0d we=%b, required 001 1 000100 4 0",
               ia.gnt, ia.mem_start, ia.mem_addr, ia.mem_nbytes, ia.mem_we);
    end
    hi = 0;
    while (ia.gnt[0] && hi < 100) begin
      step();
      hi++;
    end
    n_checks++;
    if (hi != 40) begin
      n_fail++;
      $display("FAIL fetch_gnt_len: gnt high %0d cycles, required 40", hi);
    end
    n_checks++;
    if (ia.mem_start !== 1'b0 || ia.done !== 3'b001) begin
      n_fail++;
      $display("FAIL fetch_release: start=%b done=%b when gnt fell, required 0 001", ia.mem_start, ia.done);
    end
    ia.req = 3'b000;
    wait_idle(1'b0, "fetch");
  endtask

  task automatic test_store();
    int cyc;
    bit bad;
    lat_a = 5;
    ia.req_we[REQ_LSU] = 1'b1;
    ia.req_addr[REQ_LSU] = 25'h1000020;
    ia.req_nbytes[REQ_LSU] = NBYTES_2;
    ia.req_wdata[REQ_LSU] = 32'h0000_ABCD;
    q_a.push_back('{idx: REQ_LSU, is_err: 1'b0, we: 1'b1, rd: 32'h0});
    ia.req = 3'b010;
    wait_grant(1'b0, "store", cyc);
    ia.req_we[REQ_LSU] = 1'b0;
    ia.req_addr[REQ_LSU] = 25'h0;
    ia.req_nbytes[REQ_LSU] = NBYTES_4;
    ia.req_wdata[REQ_LSU] = 32'hFFFF_FFFF;
    bad = 1'b0;
    cyc = 0;
    while (ia.gnt[1] && cyc < 50) begin
      if (ia.mem_we !== 1'b1 || ia.mem_addr !== 25'h1000020 || ia.mem_nbytes !== NBYTES_2 ||
          ia.mem_wdata !== 32'h0000_ABCD || ia.mem_start !== 1'b1)
        bad = 1'b1;
      step();
      cyc++;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL store_payload_hold: mem_* moved after grant (we=%b addr=%h), required original payload",
               ia.mem_we, ia.mem_addr);
    end
    n_checks++;
    if (ia.done !== 3'b010) begin
      n_fail++;
      $display("FAIL store_done: done=%b when gnt fell, required 010", ia.done);
    end
    ia.req = 3'b000;
    wait_idle(1'b0, "store");
  endtask

  task automatic test_fixed_priority();
    int cyc;
    lat_b = 5;
    for (int i = 0; i < 3; i++) begin
      ib.req_we[i] = 1'b0;
      ib.req_addr[i] = 25'(32'h010 * (i + 1));
      ib.req_nbytes[i] = NBYTES_1;
    end
    q_b.push_back('{idx: REQ_LSU, is_err: 1'b0, we: 1'b0, rd: mem_word(25'h020)});
    ib.req = 3'b110;
    wait_grant(1'b1, "fixed", cyc);
    n_checks++;
    if (ib.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL fixed_first: gnt=%b, required 010", ib.gnt);
    end
    ib.req[0] = 1'b1;
    q_b.push_back('{idx: REQ_FETCH, is_err: 1'b0, we: 1'b0, rd: mem_word(25'h010)});
    q_b.push_back('{idx: REQ_DBG, is_err: 1'b0, we: 1'b0, rd: mem_word(25'h030)});
    cyc = 0;
    while (q_b.size() != 0 && cyc < 200) begin
      step();
      cyc++;
      ib.req = ib.req & ~ib.done;
    end
    ib.req = 3'b000;
    wait_idle(1'b1, "fixed");
  endtask

  task automatic test_timeout();
    int cyc;
    never_b = 1'b1;
    ib.req_we[REQ_FETCH] = 1'b0;
    ib.req_addr[REQ_FETCH] = 25'h040;
    q_b.push_back('{idx: REQ_FETCH, is_err: 1'b1, we: 1'b0, rd: 32'h0});
    ib.req = 3'b001;
    wait_grant(1'b1, "timeout", cyc);
    cyc = 0;
    while (ib.err == '0 && cyc < 40) begin
      step();
      cyc++;
    end
    ib.req = 3'b000;
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL timeout_delay: err after %0d cycles, required 16", cyc);
    end
    n_checks++;
    if (ib.done !== 3'b000 || ib.mem_start !== 1'b0 || ib.gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_abort: done=%b start=%b gnt=%b, required 000 0 000", ib.done, ib.mem_start, ib.gnt);
    end
    wait_idle(1'b1, "timeout");
    never_b = 1'b0;

    lat_b = 15;
    q_b.push_back('{idx: REQ_FETCH, is_err: 1'b0, we: 1'b0, rd: mem_word(25'h040)});
    ib.req = 3'b001;
    wait_grant(1'b1, "tie", cyc);
    cyc = 0;
    while ((ib.done | ib.err) == '0 && cyc < 40) begin
      step();
      cyc++;
    end
    ib.req = 3'b000;
    n_checks++;
    if (cyc != 16 || ib.done !== 3'b001 || ib.err !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_tie: after %0d cycles done=%b err=%b, required 16 001 000", cyc, ib.done, ib.err);
    end
    wait_idle(1'b1, "tie");
  endtask

  task automatic test_reset_mid_transfer();
    int cyc;
    lat_a = 100;
    ia.req_we[REQ_FETCH] = 1'b0;
    ia.req_addr[REQ_FETCH] = 25'h080;
    ia.req = 3'b001;
    wait_grant(1'b0, "midrst", cyc);
    repeat (10) step();
    rst_n = 1'b0;
    ia.req = 3'b000;
    step();
    n_checks++;
    if (ia.mem_start !== 1'b0 || ia.gnt !== 3'b000 || ia.done !== 3'b000 || ia.err !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_outputs: start=%b gnt=%b done=%b err=%b, required all 0",
               ia.mem_start, ia.gnt, ia.done, ia.err);
    end
    n_checks++;
    if (ia.rdata !== '0) begin
      n_fail++;
      $display("FAIL midrst_rdata: got %h, required 0", ia.rdata);
    end
    last_rd_a = '0;
    last_rd_b = '0;
    rst_n = 1'b1;
    step();

    lat_a = 3;
    ia.req_addr[REQ_LSU] = 25'h0C0;
    ia.req_we[REQ_LSU] = 1'b0;
    q_a.push_back('{idx: REQ_FETCH, is_err: 1'b0, we: 1'b0, rd: mem_word(25'h080)});
    ia.req = 3'b011;
    wait_grant(1'b0, "postrst", cyc);
    n_checks++;
    if (ia.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL postrst_ptr: gnt=%b, required 001", ia.gnt);
    end
    cyc = 0;
    while (ia.done == '0 && cyc < 50) begin
      step();
      cyc++;
    end
    ia.req = 3'b000;
    wait_idle(1'b0, "postrst");
  endtask

  initial begin
    ia.req = '0; ia.req_we = '0; ia.req_addr = '0; ia.req_nbytes = '0; ia.req_wdata = '0;
    ib.req = '0; ib.req_we = '0; ib.req_addr = '0; ib.req_nbytes = '0; ib.req_wdata = '0;
    test_reset();
    test_contention_rr();
    test_single_fetch();
    test_store();
    test_fixed_priority();
    test_timeout();
    test_reset_mid_transfer();
    repeat (3) step();
    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_results: a=%0d b=%0d, required 0 0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
